complex_matrix_loader: RTL and testbench

- Upstream feeder for the 4x4 complex matrix multiplier.
- Accepts a serial stream of complex elements over a valid/ready handshake and assembles two square complex matrices, A then B, each stored as separate real and imaginary planes.
- Once both matrices are complete, presents them on flat parallel buses with a valid/ready handshake to the combinational multiplier stage.
- Single-buffered: no new input is accepted until the assembled pair is consumed.

---
 rtl/complex_matrix_loader.sv | 173 +++++++++++++++++
 tb/tb_complex_matrix_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/complex_matrix_loader.sv
// Serial-to-parallel loader for the 4x4 complex matrix multiplier: assembles
// matrix A then matrix B from a valid/ready element stream and presents the pair.
module complex_matrix_loader #(
  parameter int N      = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_real,
  input  logic [DATA_W-1:0]          in_imag,
  input  logic                       in_last,
  output logic                       mat_valid,
  input  logic                       mat_ready,
  output logic [N*N*DATA_W-1:0]      matrix_A_real,
  output logic [N*N*DATA_W-1:0]      matrix_A_imag,
  output logic [N*N*DATA_W-1:0]      matrix_B_real,
  output logic [N*N*DATA_W-1:0]      matrix_B_imag,
  output logic                       frame_err
);

  localparam int NN = N * N;
  localparam int CW = $clog2(2 * NN);
  localparam int BW = NN * DATA_W;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_next_s;
  logic [CW-1:0]   slot_s;
  logic            xfer_s;
  logic            last_idx_s;
  logic            err_s;
  logic            wr_a_s;
  logic            wr_b_s;
  logic            in_ready_r;
  logic            mat_valid_r;
  logic            frame_err_r;
  logic [BW-1:0]   a_real_r;
  logic [BW-1:0]   a_imag_r;
  logic [BW-1:0]   b_real_r;
  logic [BW-1:0]   b_imag_r;

  // B elements occupy stream indices NN..2*NN-1 but the same row-major slots as A.
  function automatic logic [CW-1:0] slot_of(input logic [CW-1:0] idx);
    logic [CW-1:0] slot;
    if (idx >= CW'(NN)) begin
      slot = idx - CW'(NN);
    end else begin
      slot = idx;
    end
    return slot;
  endfunction

  assign xfer_s     = in_valid && in_ready_r;
  assign last_idx_s = (cnt_r == CW'(2 * NN - 1));
  assign slot_s     = slot_of(cnt_r);

  // Next-state, counter and write-enable decode.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    err_s        = 1'b0;
    wr_a_s       = 1'b0;
    wr_b_s       = 1'b0;
    case (state_r)
      LOAD_A: begin
        if (xfer_s) begin
          if (in_last) begin
            err_s        = 1'b1;
            state_next_s = LOAD_A;
            cnt_next_s   = {CW{1'b0}};
          end else begin
            wr_a_s     = 1'b1;
            cnt_next_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == CW'(NN - 1)) begin
              state_next_s = LOAD_B;
            end else begin
              state_next_s = LOAD_A;
            end
          end
        end else begin
          state_next_s = LOAD_A;
        end
      end
      LOAD_B: begin
        if (xfer_s) begin
          // in_last must appear exactly on the final B element.
          if (in_last != last_idx_s) begin
            err_s        = 1'b1;
            state_next_s = LOAD_A;
            cnt_next_s   = {CW{1'b0}};
          end else if (last_idx_s) begin
            wr_b_s       = 1'b1;
            state_next_s = FULL;
            cnt_next_s   = {CW{1'b0}};
          end else begin
            wr_b_s     = 1'b1;
            cnt_next_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_next_s = LOAD_B;
        end
      end
      FULL: begin
        if (mat_valid_r && mat_ready) begin
          state_next_s = LOAD_A;
          cnt_next_s   = {CW{1'b0}};
        end else begin
          state_next_s = FULL;
        end
      end
      default: begin
        state_next_s = LOAD_A;
        cnt_next_s   = {CW{1'b0}};
      end
    endcase
  end

  // Control state plus handshake/status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= LOAD_A;
      cnt_r       <= {CW{1'b0}};
      in_ready_r  <= 1'b0;
      mat_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      in_ready_r  <= (state_next_s != FULL);
      mat_valid_r <= (state_next_s == FULL);
      frame_err_r <= err_s;
    end
  end

  // Matrix planes: only accepted, well-framed elements are written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_real_r <= {BW{1'b0}};
      a_imag_r <= {BW{1'b0}};
      b_real_r <= {BW{1'b0}};
      b_imag_r <= {BW{1'b0}};
    end else if (wr_a_s) begin
      a_real_r[int'(slot_s) * DATA_W +: DATA_W] <= in_real;
      a_imag_r[int'(slot_s) * DATA_W +: DATA_W] <= in_imag;
    end else if (wr_b_s) begin
      b_real_r[int'(slot_s) * DATA_W +: DATA_W] <= in_real;
      b_imag_r[int'(slot_s) * DATA_W +: DATA_W] <= in_imag;
    end else begin
      a_real_r <= a_real_r;
      a_imag_r <= a_imag_r;
      b_real_r <= b_real_r;
      b_imag_r <= b_imag_r;
    end
  end

  assign in_ready      = in_ready_r;
  assign mat_valid     = mat_valid_r;
  assign frame_err     = frame_err_r;
  assign matrix_A_real = a_real_r;
  assign matrix_A_imag = a_imag_r;
  assign matrix_B_real = b_real_r;
  assign matrix_B_imag = b_imag_r;

endmodule

// File: tb/tb_complex_matrix_loader.sv
// Directed, table-driven bench for complex_matrix_loader (N=4, DATA_W=8).
module tb_complex_matrix_loader;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_real;
  logic [7:0]   in_imag;
  logic         in_last;
  logic         mat_valid;
  logic         mat_ready;
  logic [127:0] matrix_A_real;
  logic [127:0] matrix_A_imag;
  logic [127:0] matrix_B_real;
  logic [127:0] matrix_B_imag;
  logic         frame_err;

  int checks = 0;
  int errors = 0;

  complex_matrix_loader #(.N(4), .DATA_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_real       (in_real),
    .in_imag       (in_imag),
    .in_last       (in_last),
    .mat_valid     (mat_valid),
    .mat_ready     (mat_ready),
    .matrix_A_real (matrix_A_real),
    .matrix_A_imag (matrix_A_imag),
    .matrix_B_real (matrix_B_real),
    .matrix_B_imag (matrix_B_imag),
    .frame_err     (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel: 0=A_real 1=A_imag 2=B_real 3=B_imag; exp is for base offset 0.
  typedef struct {
    int sel;
    int r;
    int c;
    int exp;
  } vec_t;

  vec_t vecs[8];

  function automatic int get_el(int sel, int r, int c);
    int lo;
    lo = (r * 4 + c) * 8;
    case (sel)
      0:       return int'(matrix_A_real[lo +: 8]);
      1:       return int'(matrix_A_imag[lo +: 8]);
      2:       return int'(matrix_B_real[lo +: 8]);
      3:       return int'(matrix_B_imag[lo +: 8]);
      default: return -1;
    endcase
  endfunction

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic check_table(string tag, int off);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_vec%0d", tag, i),
            get_el(vecs[i].sel, vecs[i].r, vecs[i].c), vecs[i].exp + off);
    end
  endtask

  // Present one element and hold it until it is accepted (bounded wait).
  task automatic send_elem(int re, int im, bit last);
    int waited;
    in_valid = 1'b1;
    in_real  = re[7:0];
    in_imag  = im[7:0];
    in_last  = last;
    waited   = 0;
    while (!in_ready && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Stream indices first..first+count-1 with real=base+idx, imag=100+base+idx.
  task automatic stream(int base, int first, int count, bit last_ok, bit gaps);
    for (int i = first; i < first + count; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          in_valid = 1'b0;
          in_real  = 8'($urandom);
          in_imag  = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      send_elem(base + i, 100 + base + i, last_ok && (i == 31));
    end
  endtask

  task automatic consume();
    mat_ready = 1'b1;
    @(posedge clk); #1;
    mat_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{0, 1, 2, 6};
    vecs[1] = '{3, 3, 3, 131};
    vecs[2] = '{1, 0, 0, 100};
    vecs[3] = '{2, 0, 0, 16};
    vecs[4] = '{0, 3, 3, 15};
    vecs[5] = '{2, 2, 1, 25};
    vecs[6] = '{1, 2, 3, 111};
    vecs[7] = '{3, 0, 1, 117};

    rst_n = 1'b0; in_valid = 1'b0; in_real = 8'd0; in_imag = 8'd0;
    in_last = 1'b0; mat_ready = 1'b0;
    #12;
    check("rst_mat_valid", int'(mat_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_buses_zero", int'(matrix_A_real == 128'd0 && matrix_A_imag == 128'd0 &&
          matrix_B_real == 128'd0 && matrix_B_imag == 128'd0), 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", int'(in_ready), 1);

    // Basic load, mat_valid exactly one cycle after the final transfer.
    stream(0, 0, 31, 1'b1, 1'b0);
    check("basic_valid_early", int'(mat_valid), 0);
    send_elem(31, 131, 1'b1);
    check("basic_valid", int'(mat_valid), 1);
    check("basic_ready_full", int'(in_ready), 0);
    check("basic_no_err", int'(frame_err), 0);
    check_table("basic", 0);
    in_valid = 1'b1; in_real = 8'd222; in_imag = 8'd222;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("full_hold_valid", int'(mat_valid), 1);
    check("full_hold_ready", int'(in_ready), 0);
    check("full_hold_A00", get_el(0, 0, 0), 0);

    // Consume, buses hold, then reload with +50.
    consume();
    check("consume_valid", int'(mat_valid), 0);
    check("consume_ready", int'(in_ready), 1);
    check("consume_hold_B33", get_el(3, 3, 3), 131);
    stream(50, 0, 32, 1'b1, 1'b0);
    check("reload_valid", int'(mat_valid), 1);
    check("reload_A00", get_el(0, 0, 0), 50);
    check_table("reload", 50);
    consume();

    // Backpressure with random idle cycles and junk data.
    stream(0, 0, 32, 1'b1, 1'b1);
    check("bp_valid", int'(mat_valid), 1);
    check_table("bp", 0);
    consume();

    // Early in_last on element 10.
    stream(0, 0, 10, 1'b0, 1'b0);
    check("early_no_err_yet", int'(frame_err), 0);
    send_elem(99, 99, 1'b1);
    check("early_err_pulse", int'(frame_err), 1);
    check("early_ready", int'(in_ready), 1);
    check("early_not_written", get_el(0, 2, 2), 10);
    send_elem(60, 160, 1'b0);
    check("early_err_cleared", int'(frame_err), 0);
    check("early_restart_A00", get_el(0, 0, 0), 60);
    stream(60, 1, 31, 1'b1, 1'b0);
    check("early_frame_valid", int'(mat_valid), 1);
    check("early_frame_A12", get_el(0, 1, 2), 66);
    check("early_frame_B33", get_el(3, 3, 3), 191);
    consume();

    // Missing in_last on element 31.
    stream(0, 0, 32, 1'b0, 1'b0);
    check("miss_err_pulse", int'(frame_err), 1);
    check("miss_valid", int'(mat_valid), 0);
    check("miss_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    check("miss_err_one_cycle", int'(frame_err), 0);
    stream(0, 0, 32, 1'b1, 1'b0);
    check("miss_recover_valid", int'(mat_valid), 1);
    check_table("miss_recover", 0);
    consume();

    // Asynchronous reset after 20 elements.
    stream(50, 0, 20, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_buses_zero", int'(matrix_A_real == 128'd0 && matrix_A_imag == 128'd0 &&
          matrix_B_real == 128'd0 && matrix_B_imag == 128'd0), 1);
    check("midrst_valid", int'(mat_valid), 0);
    check("midrst_ready", int'(in_ready), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready_back", int'(in_ready), 1);
    stream(0, 0, 32, 1'b1, 1'b0);
    check("midrst_frame_valid", int'(mat_valid), 1);
    check_table("midrst", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
